// File: rtl/wb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the writeback port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int c_WIDTH_DFLT  = 32;
    localparam int c_ADDR_W_DFLT = 7;
    localparam int c_ZERO_REG    = 0;

    // Bit positions inside the two-bit HI/LO enable vectors
    localparam int HILO_HI = 1;
    localparam int HILO_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_starve_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_starve_fsm
// Description : Counts cycles a secondary writer stays blocked; requests stall.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_starve_fsm
    import wb_pkg::*;
#(
    parameter int WAIT_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pending,
    input  logic granted,
    output logic stall_req
);

    localparam int c_CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(WAIT_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    wb_state_e          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;

    // stall_req is set on the same edge that enters STALL so it shows one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            stall_req <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pending) begin
                        r_cnt <= c_CNT_ONE;
                        if (c_CNT_ONE == c_CNT_MAX) begin
                            r_state   <= ST_STALL;
                            stall_req <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (granted || !pending) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == c_CNT_MAX) begin
                            r_state   <= ST_STALL;
                            stall_req <= 1'b1;
                        end
                    end
                end
                ST_STALL: begin
                    if (granted || !pending) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        stall_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    stall_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares RF and HI/LO write ports between pipeline, md and excp.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int WIDTH    = c_WIDTH_DFLT,
    parameter int ADDR_W   = c_ADDR_W_DFLT,
    parameter int WAIT_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pipe_we,
    input  logic [ADDR_W-1:0]    pipe_waddr,
    input  logic [WIDTH-1:0]     pipe_wdata,
    input  logic [1:0]           pipe_hilo_we,
    input  logic [2*WIDTH-1:0]   pipe_hilo_wdata,
    input  logic                 md_valid,
    output logic                 md_ready,
    input  logic                 md_gpr_we,
    input  logic [ADDR_W-1:0]    md_waddr,
    input  logic [1:0]           md_hilo_we,
    input  logic [2*WIDTH-1:0]   md_wdata,
    input  logic                 excp_valid,
    output logic                 excp_ready,
    input  logic [ADDR_W-1:0]    excp_waddr,
    input  logic [WIDTH-1:0]     excp_wdata,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_waddr,
    output logic [WIDTH-1:0]     rf_wdata,
    output logic [1:0]           hilo_we,
    output logic [2*WIDTH-1:0]   hilo_wdata,
    output logic                 stall_req,
    output logic                 md_drop
);

    logic w_rf_busy;
    logic w_hilo_busy;
    logic w_md_hit;
    logic w_md_ok;
    logic w_ex_ok;
    logic w_ex_gnt;
    logic w_md_gnt;
    logic w_md_gpr_wr;
    logic w_pending;
    logic w_granted;
    logic r_rr_excp;

    assign w_rf_busy   = pipe_we && (pipe_waddr != ADDR_W'(c_ZERO_REG));
    assign w_hilo_busy = |pipe_hilo_we;

    // A same-address pipeline write is younger, so it satisfies the md GPR need
    assign w_md_hit = md_valid && md_gpr_we && w_rf_busy && (md_waddr == pipe_waddr);
    assign w_md_ok  = md_valid
                   && (!(|md_hilo_we) || !w_hilo_busy)
                   && (!md_gpr_we || !w_rf_busy || w_md_hit);
    assign w_ex_ok  = excp_valid && !w_rf_busy;

    assign w_ex_gnt    = rst_n && w_ex_ok && (!w_md_ok || r_rr_excp);
    assign w_md_gnt    = rst_n && w_md_ok && !w_ex_gnt;
    assign w_md_gpr_wr = w_md_gnt && md_gpr_we && !w_md_hit;

    assign md_ready   = w_md_gnt;
    assign excp_ready = w_ex_gnt;
    assign md_drop    = w_md_gnt && w_md_hit;

    assign w_pending = (excp_valid && !w_ex_gnt) || (md_valid && !w_md_gnt);
    assign w_granted = w_ex_gnt || w_md_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_excp  <= 1'b1;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            hilo_we    <= 2'b00;
            hilo_wdata <= '0;
        end else begin
            if (w_ex_gnt) begin
                r_rr_excp <= 1'b0;
            end else if (w_md_gnt) begin
                r_rr_excp <= 1'b1;
            end

            if (w_rf_busy) begin
                rf_we    <= 1'b1;
                rf_waddr <= pipe_waddr;
                rf_wdata <= pipe_wdata;
            end else if (w_ex_gnt) begin
                rf_we    <= 1'b1;
                rf_waddr <= excp_waddr;
                rf_wdata <= excp_wdata;
            end else if (w_md_gpr_wr) begin
                rf_we    <= 1'b1;
                rf_waddr <= md_waddr;
                rf_wdata <= md_wdata[WIDTH-1:0];
            end else begin
                rf_we    <= 1'b0;
                rf_waddr <= '0;
                rf_wdata <= '0;
            end

            if (w_hilo_busy) begin
                hilo_we    <= pipe_hilo_we;
                hilo_wdata <= pipe_hilo_wdata;
            end else if (w_md_gnt && (|md_hilo_we)) begin
                hilo_we    <= md_hilo_we;
                hilo_wdata <= md_wdata;
            end else begin
                hilo_we    <= 2'b00;
                hilo_wdata <= '0;
            end
        end
    end

    wb_starve_fsm #(
        .WAIT_MAX (WAIT_MAX)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .pending   (w_pending),
        .granted   (w_granted),
        .stall_req (stall_req)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Vector table plus hand sequences for wb_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    typedef struct {
        logic        pwe;  logic [6:0] pa;  logic [31:0] pd;
        logic [1:0]  phwe; logic [63:0] phd;
        logic        mv;   logic mg; logic [6:0] ma; logic [1:0] mhwe; logic [63:0] md;
        logic        ev;   logic [6:0] ea;  logic [31:0] ed;
    } stim_t;

    typedef struct {
        logic        mr; logic er; logic dr;
        logic        rwe; logic [6:0] ra; logic [31:0] rd;
        logic [1:0]  hwe; logic [63:0] hd;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_we = 1'b0;
    logic [6:0]  pipe_waddr = '0;
    logic [31:0] pipe_wdata = '0;
    logic [1:0]  pipe_hilo_we = '0;
    logic [63:0] pipe_hilo_wdata = '0;
    logic        md_valid = 1'b0;
    logic        md_ready;
    logic        md_gpr_we = 1'b0;
    logic [6:0]  md_waddr = '0;
    logic [1:0]  md_hilo_we = '0;
    logic [63:0] md_wdata = '0;
    logic        excp_valid = 1'b0;
    logic        excp_ready;
    logic [6:0]  excp_waddr = '0;
    logic [31:0] excp_wdata = '0;
    logic        rf_we;
    logic [6:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  hilo_we;
    logic [63:0] hilo_wdata;
    logic        stall_req;
    logic        md_drop;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    vec_t tbl[9];
    logic pend_md = 1'b0;
    logic pend_ex = 1'b0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.WIDTH(32), .ADDR_W(7), .WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .pipe_hilo_we(pipe_hilo_we), .pipe_hilo_wdata(pipe_hilo_wdata),
        .md_valid(md_valid), .md_ready(md_ready), .md_gpr_we(md_gpr_we),
        .md_waddr(md_waddr), .md_hilo_we(md_hilo_we), .md_wdata(md_wdata),
        .excp_valid(excp_valid), .excp_ready(excp_ready),
        .excp_waddr(excp_waddr), .excp_wdata(excp_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
        .stall_req(stall_req), .md_drop(md_drop)
    );

    function automatic stim_t S(input logic pwe, input logic [6:0] pa, input logic [31:0] pd,
                                input logic [1:0] phwe, input logic [63:0] phd,
                                input logic mv, input logic mg, input logic [6:0] ma,
                                input logic [1:0] mhwe, input logic [63:0] md,
                                input logic ev, input logic [6:0] ea, input logic [31:0] ed);
        stim_t s;
        s.pwe = pwe; s.pa = pa; s.pd = pd; s.phwe = phwe; s.phd = phd;
        s.mv = mv; s.mg = mg; s.ma = ma; s.mhwe = mhwe; s.md = md;
        s.ev = ev; s.ea = ea; s.ed = ed;
        return s;
    endfunction

    function automatic exp_t E(input logic mr, input logic er, input logic dr,
                               input logic rwe, input logic [6:0] ra, input logic [31:0] rd,
                               input logic [1:0] hwe, input logic [63:0] hd);
        exp_t e;
        e.mr = mr; e.er = er; e.dr = dr; e.rwe = rwe; e.ra = ra; e.rd = rd;
        e.hwe = hwe; e.hd = hd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        pipe_we = s.pwe; pipe_waddr = s.pa; pipe_wdata = s.pd;
        pipe_hilo_we = s.phwe; pipe_hilo_wdata = s.phd;
        md_valid = s.mv; md_gpr_we = s.mg; md_waddr = s.ma;
        md_hilo_we = s.mhwe; md_wdata = s.md;
        excp_valid = s.ev; excp_waddr = s.ea; excp_wdata = s.ed;
    endtask

    // One clock: drive, check handshake outputs, then check the registered write
    task automatic cycle(input string tag, input stim_t s, input exp_t e);
        exp_t q;
        @(negedge clk);
        drive(s);
        sb_q.push_back(e);
        #2;
        chk({tag, ".md_ready"}, 64'(md_ready), 64'(e.mr));
        chk({tag, ".excp_ready"}, 64'(excp_ready), 64'(e.er));
        chk({tag, ".md_drop"}, 64'(md_drop), 64'(e.dr));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s.scoreboard: got empty queue expected entry", tag);
        end else begin
            q = sb_q.pop_front();
            chk({tag, ".rf_we"}, 64'(rf_we), 64'(q.rwe));
            chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(q.ra));
            chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(q.rd));
            chk({tag, ".hilo_we"}, 64'(hilo_we), 64'(q.hwe));
            chk({tag, ".hilo_wdata"}, hilo_wdata, q.hd);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(S(0,0,0,0,0, 0,0,0,0,0, 0,0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Valid must not be withdrawn before ready outside of reset
    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            pend_md = 1'b0;
            pend_ex = 1'b0;
        end else begin
            if (pend_md && !md_valid) begin
                failures++;
                $display("FAIL md_valid_withdrawn: got 0 expected 1");
            end
            if (pend_ex && !excp_valid) begin
                failures++;
                $display("FAIL excp_valid_withdrawn: got 0 expected 1");
            end
            pend_md = md_valid && !md_ready;
            pend_ex = excp_valid && !excp_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t idle;
        idle = S(0,0,0,0,0, 0,0,0,0,0, 0,0,0);

        tbl[0] = '{S(1,7'd5,32'hDEADBEEF,0,0, 0,0,0,0,0, 0,0,0), E(0,0,0, 1,7'd5,32'hDEADBEEF,0,0)};
        tbl[1] = '{S(1,7'd0,32'h1111,0,0, 0,0,0,0,0, 0,0,0), E(0,0,0, 0,0,0,0,0)};
        tbl[2] = '{S(0,0,0,0,0, 0,0,0,0,0, 1,7'h45,32'h1234), E(0,1,0, 1,7'h45,32'h1234,0,0)};
        tbl[3] = '{S(1,7'd3,32'hAAAA,0,0, 1,0,0,2'b11,64'h00000001_00000002, 0,0,0), E(1,0,0, 1,7'd3,32'hAAAA,2'b11,64'h00000001_00000002)};
        tbl[4] = '{S(0,0,0,2'b01,64'h5_00000006, 0,0,0,0,0, 1,7'd9,32'h77), E(0,1,0, 1,7'd9,32'h77,2'b01,64'h5_00000006)};
        tbl[5] = '{S(1,7'd8,32'hCAFE,0,0, 1,1,7'd8,0,64'hBAD, 0,0,0), E(1,0,1, 1,7'd8,32'hCAFE,0,0)};
        tbl[6] = '{S(1,7'd8,32'h55,0,0, 1,1,7'd8,2'b10,64'h33_00000044, 0,0,0), E(1,0,1, 1,7'd8,32'h55,2'b10,64'h33_00000044)};
        tbl[7] = '{S(0,0,0,0,0, 1,1,7'd12,0,64'h99, 0,0,0), E(1,0,0, 1,7'd12,32'h99,0,0)};
        tbl[8] = '{S(1,7'd0,32'hFFFF,0,0, 1,1,7'd4,0,64'h44, 0,0,0), E(1,0,0, 1,7'd4,32'h44,0,0)};

        do_reset();
        #2;
        chk("reset.rf_we", 64'(rf_we), 0);
        chk("reset.hilo_we", 64'(hilo_we), 0);
        chk("reset.stall_req", 64'(stall_req), 0);
        chk("reset.md_ready", 64'(md_ready), 0);
        chk("reset.excp_ready", 64'(excp_ready), 0);

        for (int i = 0; i < 9; i++) begin
            cycle($sformatf("vec%0d", i), tbl[i].s, tbl[i].e);
        end

        // md blocked on HI/LO while its GPR matches the pipeline: no drop, then retry
        cycle("hilo_block", S(1,7'd8,32'h30,2'b01,64'h7_00000008, 1,1,7'd8,2'b01,64'h10_00000020, 0,0,0),
              E(0,0,0, 1,7'd8,32'h30,2'b01,64'h7_00000008));
        cycle("hilo_retry", S(0,0,0,0,0, 1,1,7'd8,2'b01,64'h10_00000020, 0,0,0),
              E(1,0,0, 1,7'd8,32'h20,2'b01,64'h10_00000020));

        // Starvation: excp blocked by pipeline GPR writes
        for (int i = 1; i <= 5; i++) begin
            cycle($sformatf("starve%0d", i), S(1,7'd2,32'(i),0,0, 0,0,0,0,0, 1,7'h21,32'h5),
                  E(0,0,0, 1,7'd2,32'(i),0,0));
            chk($sformatf("starve%0d.stall_req", i), 64'(stall_req), 64'(i >= 4));
        end
        cycle("starve_gnt", S(0,0,0,0,0, 0,0,0,0,0, 1,7'h21,32'h5), E(0,1,0, 1,7'h21,32'h5,0,0));
        chk("starve_gnt.stall_req", 64'(stall_req), 0);

        // Round robin from a fresh reset: pointer starts at excp
        do_reset();
        cycle("rr1", S(0,0,0,0,0, 1,1,7'h12,0,64'h2, 1,7'h11,32'h1), E(0,1,0, 1,7'h11,32'h1,0,0));
        cycle("rr2", S(0,0,0,0,0, 1,1,7'h12,0,64'h2, 1,7'h13,32'h3), E(1,0,0, 1,7'h12,32'h2,0,0));
        cycle("rr3", S(0,0,0,0,0, 0,0,0,0,0, 1,7'h13,32'h3), E(0,1,0, 1,7'h13,32'h3,0,0));

        // Reset asserted while the FSM is counting
        for (int i = 0; i < 2; i++) begin
            cycle($sformatf("pre_rst%0d", i), S(1,7'd6,32'hAB,0,0, 0,0,0,0,0, 1,7'd3,32'h9),
                  E(0,0,0, 1,7'd6,32'hAB,0,0));
        end
        @(negedge clk);
        drive(S(1,7'd6,32'hAB,2'b11,64'h1, 0,0,0,0,0, 1,7'd3,32'h9));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.rf_we", 64'(rf_we), 0);
        chk("midrst.rf_waddr", 64'(rf_waddr), 0);
        chk("midrst.rf_wdata", 64'(rf_wdata), 0);
        chk("midrst.hilo_we", 64'(hilo_we), 0);
        chk("midrst.excp_ready", 64'(excp_ready), 0);
        chk("midrst.stall_req", 64'(stall_req), 0);
        @(negedge clk);
        drive(idle);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle($sformatf("post_rst%0d", i), S(1,7'd6,32'hAB,0,0, 0,0,0,0,0, 1,7'd3,32'h9),
                  E(0,0,0, 1,7'd6,32'hAB,0,0));
            chk($sformatf("post_rst%0d.stall_req", i), 64'(stall_req), 0);
        end
        cycle("post_rst_gnt", S(0,0,0,0,0, 0,0,0,0,0, 1,7'd3,32'h9), E(0,1,0, 1,7'd3,32'h9,0,0));
        cycle("final_idle", idle, E(0,0,0, 0,0,0,0,0));
        chk("sb_empty", 64'(sb_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register-file write port and the HI/LO write port between three writers:
  - the in-order pipeline writeback stage;
  - the multi-cycle multiply/divide unit (md);
  - the exception/CP0 write source (excp).
- Sits between the writeback stage and the RF/HI-LO register files.
- Pipeline writes are never delayed. Secondary writers use valid/ready handshakes. A starvation FSM requests a pipeline stall when a secondary writer waits too long.

Parameters:
WIDTH, 32, data width of one GPR/HI/LO word
ADDR_W, 7, RF write address width (GPR plus extended/CP0 space)
WAIT_MAX, 4, blocked cycles before stall_req asserts (min 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pipe_we  in  1  pipeline RF write request
pipe_waddr  in  ADDR_W  pipeline RF address
pipe_wdata  in  WIDTH  pipeline RF data
pipe_hilo_we  in  2  pipeline HI/LO write enables; [1]=HI, [0]=LO
pipe_hilo_wdata  in  2*WIDTH  pipeline {HI,LO} data
md_valid  in  1  md result pending
md_ready  out  1  md result consumed this cycle
md_gpr_we  in  1  md result targets a GPR (MUL-type)
md_waddr  in  ADDR_W  md GPR address
md_hilo_we  in  2  md HI/LO enables
md_wdata  in  2*WIDTH  md {HI,LO}; GPR data = low WIDTH bits
excp_valid  in  1  exception write pending
excp_ready  out  1  exception write consumed this cycle
excp_waddr  in  ADDR_W  exception RF address
excp_wdata  in  WIDTH  exception RF data
rf_we  out  1  registered RF write enable
rf_waddr  out  ADDR_W  registered RF address
rf_wdata  out  WIDTH  registered RF data
hilo_we  out  2  registered HI/LO enables
hilo_wdata  out  2*WIDTH  registered {HI,LO} data
stall_req  out  1  registered pipeline stall request
md_drop  out  1  one-cycle pulse: md GPR write discarded

Behaviour:
Reset and latency:
- Reset: all outputs 0; FSM in IDLE; wait counter 0; round-robin pointer at excp.
- Outputs are registered. A write granted in cycle N appears on rf_*/hilo_* in cycle N+1 for exactly one cycle.

Port occupancy (per cycle, combinational):
- RF port is busy if pipe_we=1 and pipe_waddr!=0.
- HI/LO port is busy if pipe_hilo_we!=0.
- Pipeline grant is unconditional. A write to address 0 is suppressed: rf_we stays 0.

Secondary needs:
- excp needs the RF port.
- md needs the RF port if md_gpr_we=1, and the HI/LO port if md_hilo_we!=0.
- A secondary is grantable only if every port it needs is free.

Arbitration:
- Only one secondary is granted per cycle.
- If both are grantable, the round-robin pointer decides; the pointer moves to the other source after each secondary grant.
- excp and md may be granted in the same cycle as the pipeline if their ports are disjoint, e.g. md HI/LO-only with a pipeline GPR write.
- ready rises in the grant cycle, combinationally from valid and port state.
- valid must hold stable until ready. Dropping valid before ready is illegal; the bench asserts on it.

md_drop rule:
- Applies when md_valid=1, md_gpr_we=1, md_waddr==pipe_waddr, pipe_we=1 and the address is non-zero.
- The pipeline write is younger, so the md GPR part is discarded.
- In that cycle: md_ready=1 and md_drop=1.
- Any HI/LO part of the same md request is still written if the HI/LO port is free. Otherwise both the GPR and HI/LO parts wait; no drop pulse.

Starvation FSM:
- IDLE: if any secondary valid is not granted, go to WAIT with counter=1.
- WAIT:
  - any secondary granted → IDLE, counter 0;
  - else counter+1;
  - when counter==WAIT_MAX → STALL.
- STALL: stall_req=1 (registered, asserts the cycle after entry).
  - Stays until a secondary grant, then → IDLE; stall_req drops the following cycle.
  - If valids withdraw (illegal) → IDLE.
- The counter saturates at WAIT_MAX.

Reset mid-operation:
- Pending handshakes are abandoned.
- Outputs clear immediately (asynchronous).
- Sources must re-present after rst_n releases.

Decomposition:
- Shared package wb_pkg:
  - ADDR_W and WIDTH defaults;
  - HILO_HI=1, HILO_LO=0 index constants;
  - FSM state enum {ST_IDLE, ST_WAIT, ST_STALL};
  - zero-register address constant.
- One sub-module: wb_starve_fsm. It holds the counter and state, takes "pending" and "granted" inputs, and produces stall_req.
- Port muxing and arbitration stay in the top.

Test Plan:
- Pipeline only: pipe_we=1, addr=5, data=0xDEADBEEF → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; addr=0 → rf_we=0.
- excp_valid with RF free: addr=0x45, data=0x1234 → excp_ready same cycle; next cycle rf_waddr=0x45, rf_wdata=0x1234.
- md HI/LO-only with pipeline GPR write in the same cycle: md_hilo_we=2'b11, data={0x1,0x2} → both granted; next cycle rf_we=1 and hilo_we=2'b11.
- Starvation: excp_valid held while pipe_we=1 every cycle, WAIT_MAX=4 → stall_req=1 on cycle 5. Then pipe_we=0 → excp_ready; stall_req=0 one cycle after the grant.
- Round-robin: excp and md both valid, RF free for 2 cycles, pointer at excp → excp granted first, md second.
- md_drop: md_gpr_we=1, md_waddr=8, pipe_we=1, pipe_waddr=8 → md_ready=1 and md_drop=1; only the pipeline data reaches the RF. Then assert rst_n=0 mid-WAIT → all outputs 0 immediately and the FSM returns to IDLE.
